// File: rtl/numtype_pkg.sv
// Shared binary32 / int32 number-format constants and the operand class enum
// used by the float-to-integer conversion pipeline.
package numtype_pkg;
    localparam int FRAC_W   = 23;
    localparam int EXP_W    = 8;
    localparam int SIG_W    = 24;
    localparam int INT_W    = 32;
    localparam int FRAC_LSB = 0;
    localparam int EXP_LSB  = 23;
    localparam int SIGN_BIT = 31;

    localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
    localparam logic [INT_W-1:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN  = 32'h8000_0000;

    typedef enum logic [2:0] {
        ZERO,
        SMALL,
        NORMAL,
        SAT,
        NAN
    } num_class_e;
endpackage

// File: rtl/single_to_int_pipe_if.sv
// Handshake bundle for the binary32 -> int32 converter: operand in, result plus flags out.
interface single_to_int_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] single_input;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] int_output;
    logic        overflow;
    logic        invalid;
    logic        inexact;

    modport master (
        output in_valid, single_input, out_ready,
        input  in_ready, out_valid, int_output, overflow, invalid, inexact
    );

    modport slave (
        input  in_valid, single_input, out_ready,
        output in_ready, out_valid, int_output, overflow, invalid, inexact
    );
endinterface

// File: rtl/single_mag_shift.sv
// Aligns a 24-bit significand to an integer magnitude for unbiased exponent 0..30,
// reporting whether any fraction bits were dropped.
module single_mag_shift
    import numtype_pkg::*;
(
    input  logic [SIG_W-1:0] sig,
    input  logic [4:0]       e,
    output logic [INT_W-1:0] mag,
    output logic             sticky
);
    logic [4:0]       rsh;
    logic [SIG_W-1:0] lost_mask;

    always_comb begin
        mag       = '0;
        sticky    = 1'b0;
        rsh       = '0;
        lost_mask = '0;
        if (e <= 5'd23) begin
            rsh       = 5'd23 - e;
            mag       = {8'd0, sig >> rsh};
            lost_mask = ~({SIG_W{1'b1}} << rsh);
            sticky    = |(sig & lost_mask);
        end else begin
            mag = {8'd0, sig} << (e - 5'd23);
        end
    end
endmodule

// File: rtl/single_to_int_pipe.sv
// Three-stage binary32 -> int32 converter (round toward zero, saturating) with
// valid/ready flow control; a full output stalls the whole pipe.
module single_to_int_pipe
    import numtype_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    single_to_int_pipe_if.slave  io
);
    logic stall;
    logic out_vld_q;

    assign stall       = out_vld_q & ~io.out_ready;
    assign io.in_ready = ~stall;

    function automatic logic signed [INT_W-1:0] sat_result(
        input num_class_e       cls,
        input logic             sign,
        input logic [INT_W-1:0] mag
    );
        case (cls)
            NORMAL:  return sign ? -$signed(mag) : $signed(mag);
            SAT:     return sign ? $signed(INT_MIN) : $signed(INT_MAX);
            default: return '0;
        endcase
    endfunction

    // S1: decode and classify
    logic              sign_in;
    logic [EXP_W-1:0]  exp_in;
    logic [FRAC_W-1:0] frac_in;
    num_class_e        cls_d;
    logic              inx_d, ovf_d;
    logic [4:0]        e_d;

    assign sign_in = io.single_input[SIGN_BIT];
    assign exp_in  = io.single_input[EXP_LSB +: EXP_W];
    assign frac_in = io.single_input[FRAC_LSB +: FRAC_W];

    always_comb begin
        cls_d = NORMAL;
        inx_d = 1'b0;
        ovf_d = 1'b0;
        e_d   = exp_in[4:0] - EXP_BIAS[4:0];
        if (exp_in == '0) begin
            cls_d = ZERO;
            inx_d = |frac_in;
        end else if (exp_in == EXP_MAX) begin
            cls_d = (|frac_in) ? NAN : SAT;
            ovf_d = ~(|frac_in);
        end else if (exp_in < EXP_BIAS) begin
            cls_d = SMALL;
            inx_d = 1'b1;
        end else if (exp_in >= EXP_BIAS + 8'd31) begin
            // -2^31 exactly is representable, so it saturates without overflow
            cls_d = SAT;
            ovf_d = ~((exp_in == EXP_BIAS + 8'd31) && sign_in && (frac_in == '0));
        end
    end

    logic              vld_p0, sign_p0, inx_p0, ovf_p0;
    num_class_e        cls_p0;
    logic [4:0]        e_p0;
    logic [SIG_W-1:0]  sig_p0;

    // S2: magnitude shift
    logic [INT_W-1:0]  mag_d;
    logic              sticky_d;

    single_mag_shift u_shift (
        .sig    (sig_p0),
        .e      (e_p0),
        .mag    (mag_d),
        .sticky (sticky_d)
    );

    logic              vld_p1, sign_p1, inx_p1, ovf_p1;
    num_class_e        cls_p1;
    logic [INT_W-1:0]  mag_p1;

    always_ff @(posedge clk) begin
        if (!stall) begin
            sign_p0 <= sign_in;
            cls_p0  <= cls_d;
            inx_p0  <= inx_d;
            ovf_p0  <= ovf_d;
            e_p0    <= e_d;
            sig_p0  <= {1'b1, frac_in};
            sign_p1 <= sign_p0;
            cls_p1  <= cls_p0;
            ovf_p1  <= ovf_p0;
            mag_p1  <= mag_d;
            inx_p1  <= (cls_p0 == NORMAL) ? sticky_d : inx_p0;
        end
    end

    // S3: negate/saturate into the output register
    logic signed [INT_W-1:0] int_q;
    logic                    ovf_q, inv_q, inx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_vld_q <= 1'b0;
            int_q     <= '0;
            ovf_q     <= 1'b0;
            inv_q     <= 1'b0;
            inx_q     <= 1'b0;
        end else if (!stall) begin
            vld_p0    <= io.in_valid;
            vld_p1    <= vld_p0;
            out_vld_q <= vld_p1;
            int_q     <= sat_result(cls_p1, sign_p1, mag_p1);
            ovf_q     <= ovf_p1;
            inv_q     <= (cls_p1 == NAN);
            inx_q     <= inx_p1;
        end
    end

    assign io.out_valid  = out_vld_q;
    assign io.int_output = int_q;
    assign io.overflow   = ovf_q;
    assign io.invalid    = inv_q;
    assign io.inexact    = inx_q;
endmodule

// File: tb/tb_single_to_int_pipe.sv
// Bench for single_to_int_pipe: directed spot values, stall stream, reset flush
// and a random sweep against an arithmetic conversion model.
module tb_single_to_int_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;

    logic [34:0] q_exp[$];
    int          q_cyc[$];

    single_to_int_pipe_if bus();

    single_to_int_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit %0d", $time, 1_000_000);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Result packed as {overflow, invalid, inexact, int32}; C-style truncating cast with saturation.
    function automatic logic [34:0] ref_model(input logic [31:0] f);
        int          ex;
        int          e;
        logic [22:0] fr;
        logic        s;
        longint      m, mag, sv;
        logic        inx;
        ex = int'(f[30:23]);
        fr = f[22:0];
        s  = f[31];
        if (ex == 255) begin
            if (fr != 0) return {3'b010, 32'h0};
            return {3'b100, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
        end
        if (ex == 0) return {2'b00, (fr != 0), 32'h0};
        e = ex - 127;
        m = (64'sd1 <<< 23) + longint'(fr);
        if (e > 40) return {3'b100, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
        if (e >= 23) begin
            mag = m <<< (e - 23);
            inx = 1'b0;
        end else if (e < 0) begin
            mag = 0;
            inx = 1'b1;
        end else begin
            mag = m >>> (23 - e);
            inx = ((mag <<< (23 - e)) != m);
        end
        sv = s ? -mag : mag;
        if (sv > 64'sh7FFF_FFFF || sv < -64'sh8000_0000)
            return {3'b100, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
        return {2'b00, inx, sv[31:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        logic [7:0]  ex;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       ex = r[30:23];
            1:       ex = 8'($urandom_range(100, 170));
            2:       ex = 8'($urandom_range(154, 160));
            default: begin
                ex = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h9E;
                if ($urandom_range(0, 1) == 1) r[22:0] = '0;
            end
        endcase
        return {r[31], ex, r[22:0]};
    endfunction

    task automatic step(input bit iv, input logic [31:0] d, input bit ordy,
                        input logic [34:0] ev, output bit acc);
        logic [34:0] e_front;
        int          c_front;
        @(negedge clk);
        cyc++;
        bus.in_valid     = iv;
        bus.single_input = d;
        bus.out_ready    = ordy;
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !ordy)));
        if (bus.out_valid && ordy) begin
            if (q_exp.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e_front = q_exp.pop_front();
                c_front = q_cyc.pop_front();
                chk("result", {29'd0, bus.overflow, bus.invalid, bus.inexact, bus.int_output},
                    {29'd0, e_front});
                if (lat_chk) chk("latency", 64'(cyc - c_front), 64'd3);
            end
        end
        acc = iv && bus.in_ready;
        if (acc) begin
            q_exp.push_back(ev);
            q_cyc.push_back(cyc);
        end
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && q_exp.size() != 0; i++)
            step(1'b0, 32'h0, 1'b1, 35'h0, acc);
        chk("drain_empty", 64'(q_exp.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(tag, {28'd0, bus.out_valid, bus.in_ready, bus.overflow, bus.invalid, bus.inexact,
                  bus.int_output}, {28'd0, 1'b0, 1'b1, 3'b000, 32'h0});
    endtask

    logic [31:0] dir_in  [15] = '{32'hCF00_0000, 32'hC57E_0000, 32'h3F80_0000, 32'h4D00_0000,
                                  32'h4F00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h3FC0_0000,
                                  32'hBFC0_0000, 32'h3F00_0000, 32'h8000_0000, 32'h0000_0001,
                                  32'hCF00_0001, 32'h4EFF_FFFF, 32'h7F80_0000};
    logic [34:0] dir_exp [15] = '{{3'b000, 32'h8000_0000}, {3'b000, 32'hFFFF_F020},
                                  {3'b000, 32'h0000_0001}, {3'b000, 32'h0800_0000},
                                  {3'b100, 32'h7FFF_FFFF}, {3'b100, 32'h8000_0000},
                                  {3'b010, 32'h0000_0000}, {3'b001, 32'h0000_0001},
                                  {3'b001, 32'hFFFF_FFFF}, {3'b001, 32'h0000_0000},
                                  {3'b000, 32'h0000_0000}, {3'b001, 32'h0000_0000},
                                  {3'b100, 32'h8000_0000}, {3'b000, 32'h7FFF_FF80},
                                  {3'b100, 32'h7FFF_FFFF}};

    initial begin
        bit          acc;
        logic [31:0] stream[20];
        logic [31:0] v;
        int          idx;

        bus.in_valid     = 1'b0;
        bus.single_input = 32'h0;
        bus.out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed spot values, one at a time with latency checked
        lat_chk = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, dir_in[i], 1'b1, dir_exp[i], acc);
            chk("dir_accept", 64'(acc), 64'd1);
            step(1'b0, 32'h0, 1'b1, 35'h0, acc);
        end
        drain();

        // 20-value stream with a 5-cycle output stall in the middle
        lat_chk = 1'b0;
        for (int i = 0; i < 20; i++) stream[i] = rand_operand();
        idx = 0;
        for (int i = 0; i < 60 && idx < 20; i++) begin
            step(1'b1, stream[idx], !(i >= 8 && i < 13), ref_model(stream[idx]), acc);
            if (acc) idx++;
        end
        chk("stream_sent", 64'(idx), 64'd20);
        drain();

        // Reset with three items in flight
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v = rand_operand();
            step(1'b1, v, 1'b1, ref_model(v), acc);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_flush");
        q_exp.delete();
        q_cyc.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h4D00_0000, 1'b1, {3'b000, 32'h0800_0000}, acc);
        chk("post_reset_accept", 64'(acc), 64'd1);
        drain();

        // Random sweep with random source gaps and sink back-pressure
        lat_chk = 1'b0;
        idx = 0;
        v = rand_operand();
        for (int i = 0; i < 40000 && idx < 20000; i++) begin
            step($urandom_range(0, 3) != 0, v, $urandom_range(0, 3) != 0, ref_model(v), acc);
            if (acc) begin
                idx++;
                v = rand_operand();
            end
        end
        chk("sweep_sent", 64'(idx), 64'd20000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
